// File: rtl/cc_reg_write_bank.sv
// cc_reg_write_bank
//   Write side of the datapath register bank. A bus word and binary register
//   address are captured through a valid/ready handshake into a one-entry
//   stage. The address is decoded to a one-hot select there, and the word is
//   committed to the selected register on the following unstalled edge.
//   Register 0 is hardwired to zero. Out-of-range addresses are accepted, write
//   nothing and set a sticky error flag.
// Ports
//   CC_REG_WRITE_BANK_CLOCK_50     clock, rising edge
//   CC_REG_WRITE_BANK_RESET_InLow  asynchronous active-low reset
//   CC_REG_WRITE_BANK_BUS_IN       write data
//   CC_REG_WRITE_BANK_ADDR_IN      binary destination register index
//   CC_REG_WRITE_BANK_WR_VALID     write request valid
//   CC_REG_WRITE_BANK_WR_READY     bank can accept a request this cycle (combinational)
//   CC_REG_WRITE_BANK_HOLD         datapath stall, freezes the commit stage
//   CC_REG_WRITE_BANK_ERR_CLR      clears the sticky address-error flag
//   CC_REG_WRITE_BANK_ERR          sticky out-of-range-address flag
//   CC_REG_WRITE_BANK_DECOD_SEL    one-hot select of the staged write, 0 when empty
//   CC_REG_WRITE_BANK_REG_OUT      all registers, register k at [k*BUS +: BUS]
module cc_reg_write_bank #(
   parameter int unsigned DATAWIDTH_DECODER_OUT = 38,
   parameter int unsigned DATAWIDTH_BUS         = 32,
   parameter int unsigned DATAWIDTH_ADDR        = 6
) (
   input  logic                                             CC_REG_WRITE_BANK_CLOCK_50,
   input  logic                                             CC_REG_WRITE_BANK_RESET_InLow,
   input  logic [DATAWIDTH_BUS-1:0]                         CC_REG_WRITE_BANK_BUS_IN,
   input  logic [DATAWIDTH_ADDR-1:0]                        CC_REG_WRITE_BANK_ADDR_IN,
   input  logic                                             CC_REG_WRITE_BANK_WR_VALID,
   output logic                                             CC_REG_WRITE_BANK_WR_READY,
   input  logic                                             CC_REG_WRITE_BANK_HOLD,
   input  logic                                             CC_REG_WRITE_BANK_ERR_CLR,
   output logic                                             CC_REG_WRITE_BANK_ERR,
   output logic [DATAWIDTH_DECODER_OUT-1:0]                 CC_REG_WRITE_BANK_DECOD_SEL,
   output logic [DATAWIDTH_DECODER_OUT*DATAWIDTH_BUS-1:0]   CC_REG_WRITE_BANK_REG_OUT
);

   localparam int unsigned DEC = DATAWIDTH_DECODER_OUT;
   localparam int unsigned BUS = DATAWIDTH_BUS;

   logic           stage_valid_q, stage_valid_d;
   logic [BUS-1:0] stage_data_q,  stage_data_d;
   logic [DEC-1:0] stage_sel_q,   stage_sel_d;
   logic           err_q,         err_d;

   logic ready_c;
   logic accept_c;
   logic commit_c;
   logic addr_ok_c;

   // Handshake and stage control
   always_comb begin
      ready_c   = !stage_valid_q || !CC_REG_WRITE_BANK_HOLD;
      accept_c  = CC_REG_WRITE_BANK_WR_VALID && ready_c;
      commit_c  = stage_valid_q && !CC_REG_WRITE_BANK_HOLD;
      addr_ok_c = 32'(CC_REG_WRITE_BANK_ADDR_IN) < DEC;
   end

   // Stage and error flag next state; the select is cleared whenever the stage empties
   always_comb begin
      stage_valid_d = stage_valid_q;
      stage_data_d  = stage_data_q;
      stage_sel_d   = stage_sel_q;
      err_d         = err_q;

      if (accept_c) begin
         stage_valid_d = 1'b1;
         stage_data_d  = CC_REG_WRITE_BANK_BUS_IN;
         stage_sel_d   = addr_ok_c ? (DEC'(1) << CC_REG_WRITE_BANK_ADDR_IN) : '0;
      end else if (commit_c) begin
         stage_valid_d = 1'b0;
         stage_sel_d   = '0;
      end

      // A new error in the same cycle as a clear takes priority
      if (accept_c && !addr_ok_c) begin
         err_d = 1'b1;
      end else if (CC_REG_WRITE_BANK_ERR_CLR) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge CC_REG_WRITE_BANK_CLOCK_50 or negedge CC_REG_WRITE_BANK_RESET_InLow) begin
      if (!CC_REG_WRITE_BANK_RESET_InLow) begin
         stage_valid_q <= 1'b0;
         stage_data_q  <= '0;
         stage_sel_q   <= '0;
         err_q         <= 1'b0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_data_q  <= stage_data_d;
         stage_sel_q   <= stage_sel_d;
         err_q         <= err_d;
      end
   end

   // Register file; register 0 reads as zero and swallows its writes
   for (genvar k = 0; k < DEC; k++) begin : g_reg
      if (k == 0) begin : g_zero
         assign CC_REG_WRITE_BANK_REG_OUT[0 +: BUS] = '0;
      end else begin : g_live
         logic [BUS-1:0] reg_q, reg_d;

         always_comb begin
            reg_d = reg_q;
            if (commit_c && stage_sel_q[k]) begin
               reg_d = stage_data_q;
            end
         end

         always_ff @(posedge CC_REG_WRITE_BANK_CLOCK_50 or negedge CC_REG_WRITE_BANK_RESET_InLow) begin
            if (!CC_REG_WRITE_BANK_RESET_InLow) begin
               reg_q <= '0;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign CC_REG_WRITE_BANK_REG_OUT[k*BUS +: BUS] = reg_q;
      end
   end

   assign CC_REG_WRITE_BANK_WR_READY  = ready_c;
   assign CC_REG_WRITE_BANK_ERR       = err_q;
   assign CC_REG_WRITE_BANK_DECOD_SEL = stage_sel_q;

endmodule
